sram_word_ctrl: RTL and testbench

- Initiator end of the SRAM pin protocol. Accepts 32-bit word requests from the core's data or instruction port over valid/ready.
- Drives four gf180mcu_fd_ip_sram__sram512x8m8wm1 macros (CEN/GWEN/WEN/A/D/Q) striped by byte lane, giving a 2 KiB word-addressed memory. Bank i holds byte i of each word.
- Returns read data or write completion on a valid/ready response channel, one transaction outstanding.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_word_ctrl.sv | 134 +++++++++++++
 tb/tb_sram_word_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and state type for the word-wide SRAM controller.
// Four 512x8 macros are striped by byte lane to form a 2 KiB word memory.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_N_BANKS = 4;
    localparam int unsigned SRAM_DEPTH   = 512;
    localparam int unsigned SRAM_AW      = 9;
    localparam int unsigned SRAM_DW      = 8;
    localparam int unsigned SRAM_BYTES   = 2048;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        HOLD
    } sram_ctrl_state_t;

    // Active-low bit mask for one byte lane: all bits written or none.
    function automatic logic [SRAM_DW-1:0] lane_wen(input logic strb);
        return strb ? {SRAM_DW{1'b0}} : {SRAM_DW{1'b1}};
    endfunction

endpackage

// File: rtl/sram_word_ctrl.sv
// Word-wide initiator for four byte-lane SRAM macros (gf180mcu 512x8).
// One transaction outstanding; read data comes straight from the macros in
// the cycle after the accept edge and is captured only if the response stalls.
// Optional build macro SRAM_WORD_CTRL_ERR_EN adds an rsp_err output flagging
// out-of-range or misaligned accesses.
module sram_word_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic                       req_we,
    input  logic [SRAM_N_BANKS-1:0]    req_wstrb,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_rdata,
    output logic                       CEN  [0:SRAM_N_BANKS-1],
    output logic                       GWEN [0:SRAM_N_BANKS-1],
    output logic [SRAM_DW-1:0]         WEN  [0:SRAM_N_BANKS-1],
    output logic [SRAM_AW-1:0]         A    [0:SRAM_N_BANKS-1],
    output logic [SRAM_DW-1:0]         D    [0:SRAM_N_BANKS-1],
    input  logic [SRAM_DW-1:0]         Q    [0:SRAM_N_BANKS-1]
`ifdef SRAM_WORD_CTRL_ERR_EN
    ,
    output logic                       rsp_err
`endif
);

    sram_ctrl_state_t     state_q;
    logic [31:0]          rdata_q;
    logic [31:0]          q_word;
    logic [ADDR_W-1:0]    off;
    logic [SRAM_AW-1:0]   word_addr;
    logic                 in_range;
    logic                 acc;
    logic                 rd_go;
    logic                 wr_go;

    // Address decode relative to the window base; all upper offset bits must be zero.
    assign off       = req_addr - BASE_ADDR;
    assign in_range  = (off[ADDR_W-1:11] == '0) && (off[1:0] == 2'b00);
    assign word_addr = off[10:2];

    // Handshake: a new request may be taken while the current response retires.
    assign rsp_valid = (state_q != IDLE);
    assign req_ready = !rst && ((state_q == IDLE) || (rsp_valid && rsp_ready));
    assign acc       = req_valid && req_ready;
    assign rd_go     = acc && !req_we && in_range;
    assign wr_go     = acc && req_we && in_range;

    // Per-bank pin mapping; pins are idle unless an in-range access is accepted now.
    for (genvar i = 0; i < SRAM_N_BANKS; i++) begin : g_bank
        assign CEN[i]  = rd_go ? 1'b0 : (wr_go ? ~req_wstrb[i] : 1'b1);
        assign GWEN[i] = wr_go ? ~req_wstrb[i] : 1'b1;
        assign WEN[i]  = wr_go ? lane_wen(req_wstrb[i]) : {SRAM_DW{1'b1}};
        assign A[i]    = (rd_go || wr_go) ? word_addr : '0;
        assign D[i]    = wr_go ? req_wdata[SRAM_DW*i +: SRAM_DW] : '0;
        assign q_word[SRAM_DW*i +: SRAM_DW] = Q[i];
    end

    // Response data: live macro output in RD, captured copy in HOLD.
    always_comb begin
        rsp_rdata = '0;
        unique case (state_q)
            RD:      rsp_rdata = q_word;
            HOLD:    rsp_rdata = rdata_q;
            default: rsp_rdata = '0;
        endcase
    end

    // Controller FSM; Q is only valid until the next macro access, so a stalled
    // read response is captured into rdata_q before moving to HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (acc) begin
                        state_q <= rd_go ? RD : HOLD;
                        rdata_q <= '0;
                    end
                end
                RD: begin
                    if (rsp_ready) begin
                        if (acc) begin
                            state_q <= rd_go ? RD : HOLD;
                            rdata_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        rdata_q <= q_word;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        if (acc) begin
                            state_q <= rd_go ? RD : HOLD;
                            rdata_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SRAM_WORD_CTRL_ERR_EN
    logic err_q;

    // Error flag follows each accept; it only changes when a new transaction starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (acc) begin
            err_q <= !in_range;
        end
    end

    assign rsp_err = err_q && rsp_valid;
`endif

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Self-checking bench for sram_word_ctrl with a behavioural model of the
// four byte-lane SRAM macros.
module tb_sram_word_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        cen  [0:3];
    logic        gwen [0:3];
    logic [7:0]  wen  [0:3];
    logic [8:0]  a    [0:3];
    logic [7:0]  d    [0:3];
    logic [7:0]  q    [0:3];
    logic        rsp_err_w;

    int errors = 0;
    int checks = 0;
    int act_cnt = 0;

    logic [7:0] mem [0:3][0:511];
    logic [3:0] cen_v;
    logic [3:0] gwen_v;

    always #5 clk = ~clk;

    sram_word_ctrl #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wstrb (req_wstrb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .CEN       (cen),
        .GWEN      (gwen),
        .WEN       (wen),
        .A         (a),
        .D         (d),
        .Q         (q)
`ifdef SRAM_WORD_CTRL_ERR_EN
        ,
        .rsp_err   (rsp_err_w)
`endif
    );

`ifndef SRAM_WORD_CTRL_ERR_EN
    assign rsp_err_w = 1'b0;
`endif

    assign cen_v  = {cen[3], cen[2], cen[1], cen[0]};
    assign gwen_v = {gwen[3], gwen[2], gwen[1], gwen[0]};

    // Macro model: sample on the rising edge, Q holds until the next read.
    initial for (int b = 0; b < 4; b++) q[b] = 8'h00;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!cen[b]) begin
                if (!gwen[b]) mem[b][a[b]] <= (mem[b][a[b]] & wen[b]) | (d[b] & ~wen[b]);
                else          q[b] <= mem[b][a[b]];
            end
        end
        if (cen_v != 4'hF) act_cnt <= act_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [3:0]  exp_cen;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    // Single transaction with rsp_ready high; caller sits 1 time unit after an edge.
    task automatic do_txn(input vec_t v, input string nm);
        int c0;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_wstrb = v.wstrb;
        req_wdata = v.wdata;
        rsp_ready = 1'b1;
        #1;
        chk({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({nm, " cen"}, {28'd0, cen_v}, {28'd0, v.exp_cen});
        chk({nm, " gwen"}, {28'd0, gwen_v}, {28'd0, v.we ? v.exp_cen : 4'hF});
        c0 = act_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        chk({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({nm, " rdata"}, rsp_rdata, v.exp_rdata);
`ifdef SRAM_WORD_CTRL_ERR_EN
        chk({nm, " err"}, {31'd0, rsp_err_w}, {31'd0, v.exp_err});
`endif
        chk({nm, " cen idle"}, {28'd0, cen_v}, 32'hF);
        @(posedge clk); #1;
        chk({nm, " done"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, " act cnt"}, act_cnt - c0, (v.exp_cen != 4'hF) ? 32'd1 : 32'd0);
    endtask

    vec_t vecs [0:15];
    int   c_before;

    initial begin
        vecs[0]  = '{1'b1, 32'h010, 4'hF, 32'hDEADBEEF, 4'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h010, 4'h0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h010, 4'h4, 32'h00AA0000, 4'hB, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h010, 4'h0, 32'h0,        4'h0, 32'hDEAABEEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h000, 4'hF, 32'h11223344, 4'h0, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h004, 4'hF, 32'h55667788, 4'h0, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 32'h008, 4'hF, 32'h99AABBCC, 4'h0, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 32'h004, 4'h0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h004, 4'h0, 32'h0,        4'h0, 32'h55667788, 1'b0};
        vecs[9]  = '{1'b1, 32'h7FC, 4'hF, 32'hCAFEF00D, 4'h0, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 32'h7FC, 4'h0, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b0, 32'h800, 4'h0, 32'h0,        4'hF, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 32'h013, 4'h0, 32'h0,        4'hF, 32'h0, 1'b1};
        vecs[13] = '{1'b1, 32'h900, 4'hF, 32'h12345678, 4'hF, 32'h0, 1'b1};
        vecs[14] = '{1'b0, 32'h000, 4'h0, 32'h0,        4'h0, 32'h11223344, 1'b0};
        vecs[15] = '{1'b1, 32'h1010, 4'hF, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b1};

        rst = 1'b1; req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0;
        req_wstrb = 4'h0; req_wdata = '0; rsp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset cen", {28'd0, cen_v}, 32'hF);
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post reset rsp_valid", {31'd0, rsp_valid}, 32'd0);

        for (int i = 0; i < 16; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Stalled read: RD -> HOLD, data held while a second request waits.
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h4;
        c_before = act_cnt;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("stall%0d rdata", k), rsp_rdata, 32'hDEAABEEF);
            chk($sformatf("stall%0d req_ready", k), {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("stall no cen", act_cnt - c_before, 32'd0);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall released", {31'd0, rsp_valid}, 32'd0);
        chk("stall single cen", act_cnt - c_before, 32'd0);

        // Streaming reads with both valids high: one accept per cycle.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'h4;
        #1;
        chk("stream0 rdata", rsp_rdata, 32'h11223344);
        chk("stream0 ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_addr = 32'h8;
        #1;
        chk("stream1 rdata", rsp_rdata, 32'h55667788);
        chk("stream1 ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        chk("stream2 rdata", rsp_rdata, 32'h99AABBCC);
        @(posedge clk); #1;
        chk("stream end", {31'd0, rsp_valid}, 32'd0);

        // Reset while holding a read response.
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold before rst", rsp_rdata, 32'hDEAABEEF);
        rst = 1'b1;
        #1;
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst pins idle", {28'd0, cen_v}, 32'hF);
        chk("rst ready back", {31'd0, req_ready}, 32'd1);
        do_txn(vecs[1].addr == 32'h10 ? vecs[3] : vecs[14], "after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
